// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the responder state type.
//   htrans_t           : HTRANS transfer types
//   hsize_t            : HSIZE transfer sizes (BYTE/HALF/WORD)
//   hresp_t            : HRESP bit 0 (OKAY/ERROR)
//   ahb_slave_state_t  : data-phase state of ahb_ram_slave
//   byte_enables()     : little-endian lane mask for a size/low-address pair
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } ahb_slave_state_t;

  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_if.sv
// ahb_if: AHB-Lite bus signals between one master (or mux) and one responder.
//   ahb_s : responder view (address/control/write data in, ready/resp/read data out)
//   ahb_m : master view (mirror of ahb_s)
interface ahb_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic        HMASTLOCK;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport ahb_s (
    input  HSEL, HREADY, HWRITE, HMASTLOCK, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport ahb_m (
    output HSEL, HREADY, HWRITE, HMASTLOCK, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_ram_array.sv
// ahb_ram_array: word-addressed 32-bit register-file RAM, no reset.
//   CLK   : write clock (rising edge)
//   wen   : write enable, qualified per byte by be
//   be    : byte-lane enables, bit i covers wdata[8i+7:8i]
//   addr  : word address
//   wdata : write data
//   rdata : combinational read of mem[addr]
module ahb_ram_array #(
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic          CLK,
  input  logic          wen,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_ram_slave.sv
// ahb_ram_slave: AHB-Lite responder backed by ahb_ram_array.
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   ahb  : ahb_if.ahb_s bus port (HBURST/HMASTLOCK accepted, ignored)
// Parameters: MEM_WORDS (depth, power of two), BASE_ADDR (byte address of
// word 0), WAIT_STATES (0..15 stall cycles per OKAY data phase).
// Build option: define AHB_RAM_PRIV_CHECK_EN to reject user-mode writes
// (HPROT[1]=0) with a two-cycle ERROR; otherwise HPROT is ignored.
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic CLK,
  input logic nRST,
  ahb_if.ahb_s ahb
);

  localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  ahb_slave_state_t state;
  logic [3:0]       wait_cnt;
  logic             go;          // this cycle completes an OKAY access
  logic             resp_err;
  logic             ready_out;
  logic             p_write;
  logic [2:0]       p_size;
  logic [1:0]       p_lo;
  logic [AW-1:0]    p_word;

  logic [31:0] offset;
  logic        accept;
  logic        range_err;
  logic        align_err;
  logic        size_err;
  logic        priv_err;
  logic        req_err;
  logic [31:0] rdata;
  logic        unused_ok;

  always_comb begin
    offset    = ahb.HADDR - BASE_ADDR;
    accept    = ahb.HSEL && ahb.HREADY &&
                (ahb.HTRANS == HTRANS_NONSEQ || ahb.HTRANS == HTRANS_SEQ);
    // Unsigned offset makes addresses below BASE_ADDR wrap high and fail too.
    range_err = {1'b0, offset} >= SPAN;
    size_err  = ahb.HSIZE > HSIZE_WORD;
    align_err = (ahb.HSIZE == HSIZE_HALF && ahb.HADDR[0]) ||
                (ahb.HSIZE == HSIZE_WORD && ahb.HADDR[1:0] != 2'b00);
`ifdef AHB_RAM_PRIV_CHECK_EN
    priv_err  = ahb.HWRITE && !ahb.HPROT[1];
`else
    priv_err  = 1'b0;
`endif
    req_err   = range_err || align_err || size_err || priv_err;
  end

  assign unused_ok = ^{ahb.HBURST, ahb.HMASTLOCK, ahb.HPROT};

  // IDLE, DONE and ERR2 all present HREADYOUT=1, so they share the accept path.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      go        <= 1'b0;
      resp_err  <= 1'b0;
      ready_out <= 1'b1;
      p_write   <= 1'b0;
      p_size    <= '0;
      p_lo      <= '0;
      p_word    <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= S_DONE;
            ready_out <= 1'b1;
            go        <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          ready_out <= 1'b1;
        end
        default: begin
          go        <= 1'b0;
          resp_err  <= 1'b0;
          ready_out <= 1'b1;
          state     <= S_IDLE;
          if (accept) begin
            p_write <= ahb.HWRITE;
            p_size  <= ahb.HSIZE;
            p_lo    <= ahb.HADDR[1:0];
            p_word  <= offset[AW+1:2];
            if (req_err) begin
              state     <= S_ERR1;
              ready_out <= 1'b0;
              resp_err  <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state     <= S_WAIT;
              wait_cnt  <= 4'(WAIT_STATES - 1);
              ready_out <= 1'b0;
            end else begin
              go <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  ahb_ram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .CLK   (CLK),
    .wen   (go && p_write),
    .be    (byte_enables(p_size, p_lo)),
    .addr  (p_word),
    .wdata (ahb.HWDATA),
    .rdata (rdata)
  );

  assign ahb.HREADYOUT = ready_out;
  assign ahb.HRESP     = {1'b0, resp_err};
  assign ahb.HRDATA    = (go && !p_write) ? rdata : '0;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// tb_ahb_ram_slave: directed self-checking bench for ahb_ram_slave.
// Two instances share clock and reset: dut0 (WAIT_STATES=0) and dut3
// (WAIT_STATES=3). Each bus ties HREADY back to its own HREADYOUT.
module tb_ahb_ram_slave;
  import ahb_pkg::*;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  ahb_if b0();
  ahb_if b3();

  assign b0.HREADY = b0.HREADYOUT;
  assign b3.HREADY = b3.HREADYOUT;

  ahb_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
    .CLK (clk),
    .nRST(nrst),
    .ahb (b0)
  );

  ahb_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) dut3 (
    .CLK (clk),
    .nRST(nrst),
    .ahb (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w3, input logic sel, input logic [1:0] trans,
                       input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] wdata);
    if (w3) begin
      b3.HSEL = sel; b3.HTRANS = trans; b3.HADDR = addr; b3.HWRITE = wr;
      b3.HSIZE = size; b3.HPROT = prot; b3.HWDATA = wdata;
      b3.HBURST = 3'b000; b3.HMASTLOCK = 1'b0;
    end else begin
      b0.HSEL = sel; b0.HTRANS = trans; b0.HADDR = addr; b0.HWRITE = wr;
      b0.HSIZE = size; b0.HPROT = prot; b0.HWDATA = wdata;
      b0.HBURST = 3'b000; b0.HMASTLOCK = 1'b0;
    end
  endtask

  // One NONSEQ transfer followed by idle; HSEL drops during the data phase.
  task automatic run(input bit w3, input logic wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [3:0] prot, input logic [31:0] wdata,
                     output int low, output logic [1:0] resp_first, output logic [1:0] resp_last,
                     output logic [31:0] rd_done, output bit rd_in_wait);
    logic        r;
    logic [1:0]  rs;
    logic [31:0] rd;
    bit          done;
    low = 0; rd_in_wait = 0; done = 0;
    resp_first = '0; resp_last = '0; rd_done = '0;
    drive(w3, 1'b1, HTRANS_NONSEQ, addr, wr, size, prot, 32'h0);
    tick();
    drive(w3, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 4'b0011, wdata);
    for (int i = 0; i < 40 && !done; i++) begin
      r  = w3 ? b3.HREADYOUT : b0.HREADYOUT;
      rs = w3 ? b3.HRESP : b0.HRESP;
      rd = w3 ? b3.HRDATA : b0.HRDATA;
      if (i == 0) resp_first = rs;
      if (r !== 1'b1) begin
        low++;
        if (rd !== 32'h0) rd_in_wait = 1;
        tick();
      end else begin
        resp_last = rs;
        rd_done   = rd;
        done      = 1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: addr %h got no HREADYOUT within 40 cycles", addr);
    end
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 4'b0011, 32'h0);
    drive(1, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 4'b0011, 32'h0);
    tick(); tick();
    n_checks++; if (b0.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b expected 1", b0.HREADYOUT); end
    n_checks++; if (b0.HRESP !== 2'b00) begin n_fail++; $display("FAIL reset_resp0: got %b expected 00", b0.HRESP); end
    n_checks++; if (b0.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 0", b0.HRDATA); end
    n_checks++; if (b3.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_ready3: got %b expected 1", b3.HREADYOUT); end
    n_checks++; if (b3.HRESP !== 2'b00) begin n_fail++; $display("FAIL reset_resp3: got %b expected 00", b3.HRESP); end
    n_checks++; if (b3.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3: got %h expected 0", b3.HRDATA); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 4'b0011, 32'h0);
    tick();
    n_checks++; if (b0.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready: got %b expected 1", b0.HREADYOUT); end
    n_checks++; if (b0.HRESP !== 2'b00) begin n_fail++; $display("FAIL b2b_wr_resp: got %b expected 00", b0.HRESP); end
    n_checks++; if (b0.HRDATA !== 32'h0) begin n_fail++; $display("FAIL b2b_wr_rdata: got %h expected 0", b0.HRDATA); end
    drive(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 4'b0011, 32'hDEADBEEF);
    tick();
    n_checks++; if (b0.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_ready: got %b expected 1", b0.HREADYOUT); end
    n_checks++; if (b0.HRESP !== 2'b00) begin n_fail++; $display("FAIL b2b_rd_resp: got %b expected 00", b0.HRESP); end
    n_checks++; if (b0.HRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd_data: got %h expected deadbeef", b0.HRDATA); end
    drive(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 4'b0011, 32'h0);
    tick();
    n_checks++; if (b0.HRDATA !== 32'h0) begin n_fail++; $display("FAIL b2b_after_rdata: got %h expected 0", b0.HRDATA); end
  endtask

  task automatic test_no_accept();
    logic        sels [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  trs  [3] = '{HTRANS_BUSY, HTRANS_IDLE, HTRANS_NONSEQ};
    int low; logic [1:0] rf, rl; logic [31:0] rd; bit rw;
    for (int i = 0; i < 3; i++) begin
      drive(0, sels[i], trs[i], 32'h10, 1'b1, HSIZE_WORD, 4'b0011, 32'h0);
      tick();
      drive(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 4'b0011, 32'h99999999);
      n_checks++; if (b0.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL noacc_ready[%0d]: got %b expected 1", i, b0.HREADYOUT); end
      tick();
    end
    run(0, 1'b0, 32'h10, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL noacc_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    int low; logic [1:0] rf, rl; logic [31:0] rd; bit rw;
    run(0, 1'b1, 32'h20, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    run(0, 1'b1, 32'h21, HSIZE_BYTE, 4'b0011, 32'hAAAAAAAA, low, rf, rl, rd, rw);
    n_checks++; if (low !== 0) begin n_fail++; $display("FAIL byte_wr_low: got %0d expected 0", low); end
    run(0, 1'b1, 32'h22, HSIZE_HALF, 4'b0011, 32'h12341234, low, rf, rl, rd, rw);
    run(0, 1'b0, 32'h20, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h1234AA00) begin n_fail++; $display("FAIL byte_half_data: got %h expected 1234aa00", rd); end
    run(0, 1'b1, 32'h23, HSIZE_BYTE, 4'b0011, 32'h5A5A5A5A, low, rf, rl, rd, rw);
    run(0, 1'b1, 32'h20, HSIZE_HALF, 4'b0011, 32'h00770077, low, rf, rl, rd, rw);
    run(0, 1'b0, 32'h20, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h5A340077) begin n_fail++; $display("FAIL byte_lane3_data: got %h expected 5a340077", rd); end
  endtask

  task automatic test_wait_states();
    int low; logic [1:0] rf, rl; logic [31:0] rd; bit rw;
    run(1, 1'b1, 32'h40, HSIZE_WORD, 4'b0011, 32'hCAFEF00D, low, rf, rl, rd, rw);
    n_checks++; if (low !== 3) begin n_fail++; $display("FAIL ws_wr_low: got %0d expected 3", low); end
    n_checks++; if (rl !== 2'b00) begin n_fail++; $display("FAIL ws_wr_resp: got %b expected 00", rl); end
    run(1, 1'b0, 32'h40, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (low !== 3) begin n_fail++; $display("FAIL ws_rd_low: got %0d expected 3", low); end
    n_checks++; if (rf !== 2'b00) begin n_fail++; $display("FAIL ws_rd_resp_wait: got %b expected 00", rf); end
    n_checks++; if (rw !== 1'b0) begin n_fail++; $display("FAIL ws_rd_zero_in_wait: got %b expected 0", rw); end
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws_rd_data: got %h expected cafef00d", rd); end
  endtask

  task automatic test_errors();
    int low; logic [1:0] rf, rl; logic [31:0] rd; bit rw;
    run(1, 1'b1, 32'h0, HSIZE_WORD, 4'b0011, 32'h0BADF00D, low, rf, rl, rd, rw);
    // Out of range: offset wraps onto word 0 if the check were missing.
    run(1, 1'b1, 32'h1000, HSIZE_WORD, 4'b0011, 32'h11111111, low, rf, rl, rd, rw);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL err_range_low: got %0d expected 1", low); end
    n_checks++; if (rf !== 2'b01) begin n_fail++; $display("FAIL err_range_resp1: got %b expected 01", rf); end
    n_checks++; if (rl !== 2'b01) begin n_fail++; $display("FAIL err_range_resp2: got %b expected 01", rl); end
    run(1, 1'b1, 32'h2, HSIZE_WORD, 4'b0011, 32'h22222222, low, rf, rl, rd, rw);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL err_align_low: got %0d expected 1", low); end
    n_checks++; if (rl !== 2'b01) begin n_fail++; $display("FAIL err_align_resp2: got %b expected 01", rl); end
    run(1, 1'b0, 32'h0, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_ram_unchanged: got %h expected 0badf00d", rd); end
    run(0, 1'b0, 32'h1, HSIZE_HALF, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL err_half_low: got %0d expected 1", low); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_half_rdata: got %h expected 0", rd); end
    run(0, 1'b0, 32'h10, 3'd3, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rl !== 2'b01) begin n_fail++; $display("FAIL err_size_resp: got %b expected 01", rl); end
  endtask

  task automatic test_reset_mid();
    int low; logic [1:0] rf, rl; logic [31:0] rd; bit rw;
    run(1, 1'b1, 32'h80, HSIZE_WORD, 4'b0011, 32'h55555555, low, rf, rl, rd, rw);
    drive(1, 1'b1, HTRANS_NONSEQ, 32'h80, 1'b1, HSIZE_WORD, 4'b0011, 32'h0);
    tick();
    drive(1, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 4'b0011, 32'hAAAAAAAA);
    n_checks++; if (b3.HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_wait: got %b expected 0", b3.HREADYOUT); end
    tick();
    #2 nrst = 1'b0;
    #1;
    n_checks++; if (b3.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", b3.HREADYOUT); end
    n_checks++; if (b3.HRESP !== 2'b00) begin n_fail++; $display("FAIL rstmid_resp: got %b expected 00", b3.HRESP); end
    n_checks++; if (b3.HRDATA !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0", b3.HRDATA); end
    tick(); tick();
    nrst = 1'b1;
    tick();
    run(1, 1'b0, 32'h80, HSIZE_WORD, 4'b0011, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h55555555) begin n_fail++; $display("FAIL rstmid_old_data: got %h expected 55555555", rd); end
    n_checks++; if (low !== 3) begin n_fail++; $display("FAIL rstmid_read_low: got %0d expected 3", low); end
  endtask

  task automatic test_hprot();
    int low; logic [1:0] rf, rl; logic [31:0] rd; bit rw;
`ifdef AHB_RAM_PRIV_CHECK_EN
    run(0, 1'b1, 32'h60, HSIZE_WORD, 4'b0011, 32'h01010101, low, rf, rl, rd, rw);
    run(0, 1'b1, 32'h60, HSIZE_WORD, 4'b0001, 32'h02020202, low, rf, rl, rd, rw);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL priv_user_low: got %0d expected 1", low); end
    n_checks++; if (rl !== 2'b01) begin n_fail++; $display("FAIL priv_user_resp: got %b expected 01", rl); end
    run(0, 1'b0, 32'h60, HSIZE_WORD, 4'b0000, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h01010101) begin n_fail++; $display("FAIL priv_no_update: got %h expected 01010101", rd); end
    run(0, 1'b1, 32'h60, HSIZE_WORD, 4'b0011, 32'h03030303, low, rf, rl, rd, rw);
    n_checks++; if (rl !== 2'b00) begin n_fail++; $display("FAIL priv_ok_resp: got %b expected 00", rl); end
    run(0, 1'b0, 32'h60, HSIZE_WORD, 4'b0000, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h03030303) begin n_fail++; $display("FAIL priv_update: got %h expected 03030303", rd); end
`else
    run(0, 1'b1, 32'h60, HSIZE_WORD, 4'b0001, 32'h01010101, low, rf, rl, rd, rw);
    n_checks++; if (low !== 0) begin n_fail++; $display("FAIL hprot_ign_low: got %0d expected 0", low); end
    n_checks++; if (rl !== 2'b00) begin n_fail++; $display("FAIL hprot_ign_resp: got %b expected 00", rl); end
    run(0, 1'b0, 32'h60, HSIZE_WORD, 4'b0000, 32'h0, low, rf, rl, rd, rw);
    n_checks++; if (rd !== 32'h01010101) begin n_fail++; $display("FAIL hprot_ign_data: got %h expected 01010101", rd); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_back_to_back();
    test_no_accept();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_reset_mid();
    test_hprot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
- AHB-Lite responder (slave end) on the ahb_if bus, attached through the ahb_s modport.
- Backs a word-addressed register-file RAM.
- Supports byte, halfword and word transfers, a parameterised number of wait states, and two-cycle ERROR responses.
- Sits behind the bus mux/decoder as the target for core instruction/data fetch and for the testbench scratch memory.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per OKAY data phase; range 0–15.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- ahb  ahb_if.ahb_s  –  carries the following signals:
  - HSEL, HREADY, HWRITE, HMASTLOCK  input  1 each.
  - HTRANS  input  2.
  - HSIZE, HBURST  input  3 each.
  - HPROT  input  4.
  - HADDR, HWDATA  input  32 each.
  - HREADYOUT  output  1.
  - HRESP  output  2 (bit 0 = ERROR, bit 1 tied 0).
  - HRDATA  output  32.
- HBURST and HMASTLOCK are accepted but ignored.

Behaviour:
- Reset (nRST low, asynchronous):
  - HREADYOUT=1, HRESP=OKAY, HRDATA=0, state=IDLE, pending-transfer registers cleared.
  - RAM contents are not reset.
- Address-phase accept: HSEL & HREADY & HTRANS∈{NONSEQ,SEQ}.
  - Register HADDR, HWRITE, HSIZE and the error check result.
  - The data phase starts the next cycle.
- IDLE/BUSY, or no accept: the next data phase is zero-wait OKAY with no RAM access.
- Error check, evaluated at accept:
  - Out of range: (HADDR-BASE_ADDR) ≥ MEM_WORDS*4.
  - Misaligned: HSIZE=HALF with HADDR[0]=1, or HSIZE=WORD with HADDR[1:0]≠0.
  - Unsupported size: HSIZE>WORD.
- States:
  - IDLE: no data phase stalled.
    - Accept with error → ERR1.
    - Accept OK with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
    - Accept OK with WAIT_STATES=0 → stay in IDLE; the data phase completes next cycle.
  - WAIT: HREADYOUT=0, HRESP=OKAY, counter decrements each cycle. At 0 → DONE.
  - DONE: HREADYOUT=1, HRESP=OKAY, access performed. Accept in this cycle follows the IDLE rules; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR, no RAM access. A new accept in this cycle is processed as from IDLE.
- Zero-wait OK data phase: it is the cycle after accept; HREADYOUT=1 and the access is performed.
- Read:
  - HRDATA is the full word at the latched address, driven only in the completing cycle (HREADYOUT=1, OKAY).
  - HRDATA=0 otherwise.
  - No byte-lane masking on reads; the master selects lanes.
- Write:
  - Committed at the rising edge ending the completing cycle, using HWDATA sampled in that cycle.
  - Little-endian byte enables: BYTE → lane HADDR[1:0]; HALF → lanes {HADDR[1],0}+{0,1}; WORD → all lanes.
- Back-to-back: a write followed by a read of the same address returns the new data. The write commits before the read's data phase, and RAM read is combinational on the latched address.
- HSEL low during an in-progress data phase does not abort it; the data phase is owned by the latched transfer.
- Reset mid-transfer: the pending write is dropped and the bus returns to IDLE.

Optional Feature:
- Macro: AHB_RAM_PRIV_CHECK_EN.
- Defined: a write with HPROT[1]=0 (user access) is an error at accept and takes the ERR1/ERR2 path with no RAM update. Reads are unaffected.
- Undefined: HPROT is ignored entirely.

Decomposition:
- ahb_pkg holds:
  - HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - HSIZE encodings (BYTE=0, HALF=1, WORD=2).
  - HRESP encodings (OKAY=0, ERROR=1).
  - ahb_slave_state_t {IDLE, WAIT, DONE, ERR1, ERR2}.
- One sub-module, ahb_ram_array:
  - Parameter MEM_WORDS.
  - Ports: CLK, wen, 4-bit byte enable, word address, wdata, combinational rdata.

Test Plan:
- Reset, WAIT_STATES=0:
  - Write WORD 0xDEADBEEF to 0x10, then read 0x10 back-to-back.
  - Expect HREADYOUT never low, HRESP=OKAY, HRDATA=0xDEADBEEF.
- Byte writes: write BYTE 0xAA to 0x21 and HALF 0x1234 to 0x22 over word 0x20 (preset 0).
  - Read 0x20 → 0x1234AA00.
- WAIT_STATES=3, read:
  - Exactly 3 cycles HREADYOUT=0 after accept, then 1 cycle HREADYOUT=1 with data.
  - HRDATA=0 during the wait cycles.
- Errors:
  - HADDR=BASE_ADDR+MEM_WORDS*4: ERR1 then ERR2 (HRESP=1 both cycles, HREADYOUT 0 then 1), RAM unchanged.
  - Same for WORD at 0x02.
- Reset mid-transfer: nRST low during the WAIT of a write.
  - Outputs return to reset values immediately.
  - A subsequent read shows the old data.
- With AHB_RAM_PRIV_CHECK_EN:
  - Write with HPROT=4'b0001 → two-cycle ERROR, no update.
  - Same write with HPROT=4'b0011 → OKAY and update.
